// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared types for the local-port inject arbiter: flit preamble layout and arbiter FSM states.
package noc_local_inject_arbiter_pkg;

    // Top two bits of every flit; head is the MSB, tail sits directly below it.
    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    localparam int unsigned PREAMBLE_W = $bits(preamble_t);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_local_inject_arbiter_if.sv
// Flit handshake bundle between the requesters, the inject arbiter and the router local input.
interface noc_local_inject_arbiter_if #(
    parameter int unsigned Width = 32,
    parameter int unsigned NReq  = 4
);
    logic [NReq-1:0][Width-1:0] req_data_in;
    logic [NReq-1:0]            req_void_in;
    logic [NReq-1:0]            req_stop_out;
    logic [Width-1:0]           data_p_out;
    logic                       data_void_out;
    logic                       stop_p_in;

    modport slave (
        input  req_data_in,
        input  req_void_in,
        input  stop_p_in,
        output req_stop_out,
        output data_p_out,
        output data_void_out
    );

    modport master (
        output req_data_in,
        output req_void_in,
        output stop_p_in,
        input  req_stop_out,
        input  data_p_out,
        input  data_void_out
    );
endinterface

// File: rtl/noc_local_inject_arbiter_rr.sv
// noc_rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap at NReq.
module noc_rr_arbiter #(
    parameter  int unsigned NReq = 4,
    localparam int unsigned IdxW = $clog2(NReq)
) (
    input  logic [NReq-1:0] i_req,
    input  logic [IdxW-1:0] i_ptr,
    output logic [NReq-1:0] o_gnt,
    output logic [IdxW-1:0] o_idx
);

    logic            w_found;
    logic [IdxW-1:0] w_j;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int unsigned k = 1; k <= NReq; k++) begin
            w_j = IdxW'((32'(i_ptr) + k) % NReq);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one router local input among NReq flit sources.
// Optional per-requester packet counters are built when NOC_INJECT_STATS_EN is defined.
module noc_local_inject_arbiter
    import noc_local_inject_arbiter_pkg::*;
#(
    parameter  int unsigned Width    = 32,
    parameter  int unsigned NReq     = 4,
    parameter  int unsigned CntWidth = 16,
    localparam int unsigned IdxW     = $clog2(NReq)
) (
    input  logic                     clk,
    input  logic                     rst,
    noc_local_inject_arbiter_if.slave bus,
    output logic [IdxW-1:0]          grant_idx_out,
    output logic                     busy_out,
    output logic [NReq*CntWidth-1:0] pkt_count_out
);

    arb_state_e      r_state, w_state_nxt;
    logic [IdxW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [IdxW-1:0] r_grant_idx, w_grant_idx_nxt;
    logic [Width-1:0] r_data;
    logic            r_void;

    preamble_t       w_pre [NReq];
    logic [NReq-1:0] w_head, w_tail, w_cand;
    logic [NReq-1:0] w_rr_gnt, w_gnt;
    logic [IdxW-1:0] w_rr_idx, w_sel;
    logic            w_ld_ok, w_acc;

    for (genvar i = 0; i < NReq; i++) begin : g_pre
        assign w_pre[i]  = preamble_t'(bus.req_data_in[i][Width-1 -: PREAMBLE_W]);
        assign w_head[i] = w_pre[i].head;
        assign w_tail[i] = w_pre[i].tail;
    end

    // Only non-void head flits may open a packet; stray body flits in IDLE stay stalled.
    assign w_cand  = ~bus.req_void_in & w_head;
    assign w_ld_ok = r_void || !bus.stop_p_in;

    noc_rr_arbiter #(.NReq(NReq)) u_rr (
        .i_req (w_cand),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= IdxW'(NReq - 1);
            r_grant_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_idx <= w_grant_idx_nxt;
        end
    end

    // r_grant_idx doubles as the packet owner while LOCKED.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_idx_nxt = r_grant_idx;
        w_gnt           = '0;
        w_sel           = r_grant_idx;
        w_acc           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt = w_rr_gnt;
                w_sel = w_rr_idx;
                if (w_ld_ok && (|w_rr_gnt)) begin
                    w_acc           = 1'b1;
                    w_grant_idx_nxt = w_rr_idx;
                    if (w_tail[w_rr_idx]) begin
                        w_rr_ptr_nxt = w_rr_idx;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                w_gnt[r_grant_idx] = 1'b1;
                if (w_ld_ok && !bus.req_void_in[r_grant_idx]) begin
                    w_acc = 1'b1;
                    if (w_tail[r_grant_idx]) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = r_grant_idx;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output stage: load on accept, void when draining with nothing new, hold under stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_void <= 1'b1;
            r_data <= '0;
        end else if (w_ld_ok) begin
            if (w_acc) begin
                r_data <= bus.req_data_in[w_sel];
                r_void <= 1'b0;
            end else begin
                r_void <= 1'b1;
            end
        end
    end

    assign bus.req_stop_out  = {NReq{rst}} | ~({NReq{w_ld_ok}} & w_gnt);
    assign bus.data_p_out    = r_data;
    assign bus.data_void_out = r_void;
    assign grant_idx_out     = r_grant_idx;
    assign busy_out          = (r_state == ST_LOCKED);

`ifdef NOC_INJECT_STATS_EN
    logic [NReq-1:0][CntWidth-1:0] r_cnt;

    // Saturating count of accepted tail flits per requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NReq; i++) begin
                if (w_acc && (w_sel == IdxW'(i)) && w_tail[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CntWidth'(1);
                end
            end
        end
    end

    assign pkt_count_out = r_cnt;
`else
    assign pkt_count_out = '0;
`endif

endmodule
